cpu_datapath: RTL
=================

Name: cpu_datapath

Overview:
- Datapath consumed by the 8-phase control sequencer. It receives rd/ld_ir/ld_acc/ld_pc/inc_pc/halt/data_e/sel and returns opcode and zero.
- Holds the instruction register (IR), program counter (PC), accumulator (ACC) and ALU.
- Drives the memory address and write data, and accepts memory read data.
- Together with the sequencer and memory, it forms the complete 8-bit accumulator CPU.

Parameters:
- DATA_WIDTH, 8, width of the data bus, IR and ACC.
- ADDR_WIDTH, 5, width of the memory address, PC and the IR operand field.
- OPCODE_WIDTH, 3, opcode field at IR[DATA_WIDTH-1 -: OPCODE_WIDTH]; DATA_WIDTH = OPCODE_WIDTH + ADDR_WIDTH is required.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high. Clears IR, PC and ACC immediately.
- ld_ir  input  1  load IR from mem_rdata.
- ld_acc  input  1  load ACC from ALU result.
- ld_pc  input  1  load PC from IR operand field.
- inc_pc  input  1  PC <= PC+1.
- halt  input  1  freeze all registers while high.
- data_e  input  1  enable write-data drive.
- sel  input  1  address select: 1 = PC, 0 = IR operand.
- mem_rdata  input  DATA_WIDTH  memory read data.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  equals ACC when data_e=1, else 0.
- mem_wdata_oe  output  1  equals data_e; qualifies mem_wdata.
- opcode  output  OPCODE_WIDTH  IR opcode field, to the sequencer.
- zero  output  1  (ACC == 0), combinational, to the sequencer.
- pc_out  output  ADDR_WIDTH  current PC, for debug and the bench.

Behaviour:
- Reset: IR=0, PC=0, ACC=0. Resulting outputs: opcode=0 (HLT), zero=1, mem_addr=PC=0 when sel=1, mem_wdata=0, mem_wdata_oe=0. Reset asserted mid-instruction aborts immediately, with no partial update.
- IR: on posedge with ld_ir=1 and halt=0, IR <= mem_rdata. opcode and operand are valid from the next cycle.
- PC, on posedge with halt=0:
  - ld_pc=1: PC <= IR operand. ld_pc has priority over inc_pc when both are asserted.
  - else inc_pc=1: PC <= PC+1, wrapping modulo 2^ADDR_WIDTH (31 -> 0).
  - else PC holds.
  - SKZ is two inc_pc pulses in one fetch cycle, driven by the sequencer. The datapath only obeys the strobes.
- ALU: combinational from opcode, ACC and mem_rdata. Result width is DATA_WIDTH; carry is discarded (ADD wraps 8'hFF+1 -> 0).
  - HLT/SKZ/STO/JMP: pass ACC.
  - ADD: ACC+data.
  - AND: ACC&data.
  - XOR: ACC^data.
  - LDA: data.
- ACC: on posedge with ld_acc=1 and halt=0, ACC <= ALU result. zero updates in the same cycle as ACC.
- mem_addr = sel ? PC : IR[ADDR_WIDTH-1:0]. This is combinational, with no register stage.
- mem_wdata and mem_wdata_oe follow data_e combinationally. ACC is stable while data_e is high because the sequencer never asserts ld_acc with data_e.
- Simultaneous ld_ir and ld_acc: both update. ACC uses the ALU result computed from the old IR opcode.
- halt=1: every register holds regardless of load strobes. Only rst or halt deassertion resumes operation.
- Outputs for unknown/X on strobes are undefined. The bench drives only 0/1.

Decomposition:
- Shared package cpu_defs:
  - Opcode localparams OP_HLT=0, OP_SKZ=1, OP_ADD=2, OP_AND=3, OP_XOR=4, OP_LDA=5, OP_STO=6, OP_JMP=7.
  - Width constants DATA_WIDTH, ADDR_WIDTH, OPCODE_WIDTH.
  - The same package is used by the sequencer.
- One sub-module: cpu_alu, a purely combinational opcode/ACC/data -> result block.
- Registers and address mux stay in cpu_datapath.

Test Plan:
- Reset then idle: assert rst for 3 cycles with random strobes -> IR=0, PC=0, ACC=0, zero=1, opcode=0, mem_wdata_oe=0.
- Fetch + LDA:
  - mem_rdata=8'hA3 with ld_ir -> opcode=5, mem_addr(sel=0)=5'h03.
  - Then mem_rdata=8'h00 with ld_acc -> ACC=0, zero=1.
  - Then LDA 8'h7F -> ACC=8'h7F, zero=0.
- ALU ops from ACC=8'hFF:
  - ADD data 8'h01 -> ACC=8'h00, zero=1 (wrap).
  - AND 8'h0F on ACC=8'h3C -> 8'h0C.
  - XOR 8'hFF on ACC=8'h0C -> 8'hF3.
- PC:
  - inc_pc from PC=31 -> 0.
  - IR=8'hF5 (JMP 0x15) with ld_pc and inc_pc both high -> PC=5'h15.
  - Two inc_pc pulses from 4 -> 6.
- STO: ACC=8'h5A, data_e=1, sel=0, IR operand=5'h1E -> mem_addr=5'h1E, mem_wdata=8'h5A, mem_wdata_oe=1. data_e=0 -> mem_wdata=0, oe=0.
- Halt and mid-op reset:
  - halt=1 with ld_ir/ld_acc/inc_pc all pulsed -> IR, ACC and PC unchanged for 5 cycles.
  - Assert rst between clock edges -> registers clear before the next posedge.

Source files
------------

// File: rtl/cpu_datapath_pkg.sv
// Shared definitions for the 8-bit accumulator CPU.
// The sequencer imports the same package, so the opcode encodings and
// field widths are defined here only.
package cpu_defs;

    // Bus and field widths. The instruction word is opcode followed by operand.
    localparam int DATA_WIDTH   = 8;
    localparam int ADDR_WIDTH   = 5;
    localparam int OPCODE_WIDTH = 3;

    // Opcode encodings held in IR[DATA_WIDTH-1 -: OPCODE_WIDTH].
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 3'd0;
    localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = 3'd1;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 3'd2;
    localparam logic [OPCODE_WIDTH-1:0] OP_AND = 3'd3;
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR = 3'd4;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 3'd5;
    localparam logic [OPCODE_WIDTH-1:0] OP_STO = 3'd6;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 3'd7;

    // Decoded view of an instruction word.
    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [ADDR_WIDTH-1:0]   operand;
    } instr_t;

    // Split a raw instruction word into its opcode and operand fields.
    function automatic instr_t decode_instr(input logic [DATA_WIDTH-1:0] word);
        instr_t r;
        r.opcode  = word[DATA_WIDTH-1 -: OPCODE_WIDTH];
        r.operand = word[ADDR_WIDTH-1:0];
        return r;
    endfunction

endpackage

// File: rtl/cpu_datapath_alu.sv
// Combinational ALU of the accumulator CPU.
// Operates on the accumulator and the memory read data. The result has the
// width of the data bus, so any carry out of ADD is dropped.
module cpu_alu
    import cpu_defs::*;
(
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [DATA_WIDTH-1:0]   acc,
    input  logic [DATA_WIDTH-1:0]   data,
    output logic [DATA_WIDTH-1:0]   result
);

    // Select the operation; opcodes that do not touch ACC pass it through.
    always_comb begin
        result = acc;
        case (opcode)
            OP_ADD:  result = acc + data;
            OP_AND:  result = acc & data;
            OP_XOR:  result = acc ^ data;
            OP_LDA:  result = data;
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// Datapath of the 8-bit accumulator CPU.
// Holds IR, PC and ACC, drives the memory address and write data, and
// reports opcode and zero back to the control sequencer. All registers are
// frozen while halt is high; rst clears them asynchronously.
module cpu_datapath
    import cpu_defs::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_ir,
    input  logic                    ld_acc,
    input  logic                    ld_pc,
    input  logic                    inc_pc,
    input  logic                    halt,
    input  logic                    data_e,
    input  logic                    sel,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic                    mem_wdata_oe,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic                    zero,
    output logic [ADDR_WIDTH-1:0]   pc_out
);

    // Architectural registers and their next-state values.
    logic [DATA_WIDTH-1:0] ir_q,  ir_d;
    logic [ADDR_WIDTH-1:0] pc_q,  pc_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;

    instr_t                instr;
    logic [DATA_WIDTH-1:0] alu_result;

    assign instr = decode_instr(ir_q);

    // The ALU always sees the opcode currently in IR, so a simultaneous
    // ld_ir and ld_acc computes ACC from the old instruction.
    cpu_alu u_alu (
        .opcode (instr.opcode),
        .acc    (acc_q),
        .data   (mem_rdata),
        .result (alu_result)
    );

    // IR next state: capture the fetched word unless halted.
    always_comb begin
        ir_d = ir_q;
        if (!halt && ld_ir) begin
            ir_d = mem_rdata;
        end
    end

    // PC next state: a jump target wins over increment; increment wraps.
    always_comb begin
        pc_d = pc_q;
        if (!halt) begin
            if (ld_pc) begin
                pc_d = instr.operand;
            end else if (inc_pc) begin
                pc_d = pc_q + ADDR_WIDTH'(1);
            end
        end
    end

    // ACC next state: take the ALU result unless halted.
    always_comb begin
        acc_d = acc_q;
        if (!halt && ld_acc) begin
            acc_d = alu_result;
        end
    end

    // Register update; reset clears everything at once, mid-instruction too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q  <= '0;
            pc_q  <= '0;
            acc_q <= '0;
        end else begin
            ir_q  <= ir_d;
            pc_q  <= pc_d;
            acc_q <= acc_d;
        end
    end

    // Address mux has no register stage: PC for fetches, operand for data.
    assign mem_addr     = sel ? pc_q : instr.operand;

    // Write data is only driven while data_e qualifies it.
    assign mem_wdata    = data_e ? acc_q : '0;
    assign mem_wdata_oe = data_e;

    // Status back to the sequencer and debug view of PC.
    assign opcode       = instr.opcode;
    assign zero         = (acc_q == '0);
    assign pc_out       = pc_q;

endmodule
